// File: rtl/ervp_valid_once_generator_if.sv
// Level-to-pulse handshake bundle: producer level in, ack back, pulse out.
// Latency: none, wires only.
// Backpressure: none; the producer holds valid_extended until invalidate returns.
interface ervp_valid_once_generator_if;
  logic valid_extended;
  logic invalidate;
  logic valid_once;

  modport master (
    output valid_extended,
    input  invalidate,
    input  valid_once
  );

  modport slave (
    input  valid_extended,
    output invalidate,
    output valid_once
  );
endinterface

// File: rtl/ervp_valid_once_generator.sv
// Turns a level-held valid into one single-cycle valid_once pulse plus a one-cycle invalidate.
// Latency: pulse 1 cycle after the level is sampled high with enable; re-arm after release/gap.
// Backpressure: none downstream; producer is held off by busy/invalidate. Option ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN.
module ervp_valid_once_generator #(
  parameter int unsigned GAP_CYCLES       = 0,
  parameter bit          REQUIRE_DEASSERT = 1'b1,
  parameter int unsigned COUNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        enable,
  ervp_valid_once_generator_if.slave  handshake,
  output logic                        busy,
  output logic [COUNT_WIDTH-1:0]      fire_count,
  output logic                        timeout_error
);

  typedef enum logic [1:0] {IDLE, FIRE, RELEASE, GAP} state_t;

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam state_t AFTER_RELEASE = (GAP_CYCLES > 0) ? GAP : IDLE;
  localparam state_t AFTER_FIRE    = REQUIRE_DEASSERT ? RELEASE : AFTER_RELEASE;

  state_t           state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic             valid_once_q, invalidate_q;

`ifdef ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] rel_cnt, rel_next;
  logic             timeout_hit;
`endif

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
`ifdef ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
    rel_next    = rel_cnt;
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable && handshake.valid_extended) state_next = FIRE;
      end
      FIRE: begin
        state_next = AFTER_FIRE;
`ifdef ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
        rel_next = '0;
`endif
      end
      RELEASE: begin
        if (!handshake.valid_extended) begin
          state_next = AFTER_RELEASE;
        end
`ifdef ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
        // A stuck level is treated as if it had dropped, but flagged.
        else if (rel_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = AFTER_RELEASE;
        end else begin
          rel_next = rel_cnt + TMO_W'(1);
        end
`endif
      end
      GAP: begin
        gap_next = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next == GAP && state != GAP) gap_next = GAP_LOAD;

    if (clear) begin
      state_next = IDLE;
      gap_next   = '0;
`ifdef ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
      rel_next    = '0;
      timeout_hit = 1'b0;
`endif
    end
  end

  // Outputs are decoded from state_next so they appear registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      valid_once_q <= 1'b0;
      invalidate_q <= 1'b0;
      busy         <= 1'b0;
      fire_count   <= '0;
    end else begin
      state        <= state_next;
      gap_cnt      <= gap_next;
      valid_once_q <= (state_next == FIRE);
      invalidate_q <= (state_next == FIRE);
      busy         <= (state_next != IDLE);
      if (clear) begin
        fire_count <= '0;
      end else if (state_next == FIRE && fire_count != '1) begin
        fire_count <= fire_count + COUNT_WIDTH'(1);
      end
    end
  end

`ifdef ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_cnt       <= '0;
      timeout_error <= 1'b0;
    end else begin
      rel_cnt <= rel_next;
      if (clear)            timeout_error <= 1'b0;
      else if (timeout_hit) timeout_error <= 1'b1;
    end
  end
`else
  assign timeout_error = 1'b0;
`endif

  assign handshake.valid_once = valid_once_q;
  assign handshake.invalidate = invalidate_q;

endmodule

// File: doc/ervp_valid_once_generator.md
Name: ervp_valid_once_generator

Overview:
- Counterpart of the valid-once capturer.
- Takes a level-held valid from a producer, emits exactly one single-cycle valid_once pulse downstream, and returns a one-cycle invalidate so the producer drops its level.
- Enforces re-arm (level must fall) and a programmable minimum gap between pulses.
- Sits between capturer-style request holders and pulse-driven consumers such as interrupt, DMA-kick and event ports.

Parameters:
- GAP_CYCLES, 0: idle cycles forced after each pulse before the next may fire; 0 means no GAP state.
- REQUIRE_DEASSERT, 1: 1 means valid_extended must be seen low before re-arming; 0 means re-arm immediately.
- COUNT_WIDTH, 8: width of the saturating fire counter.
- TIMEOUT_CYCLES, 16: RELEASE timeout limit; used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- clear  input  1  synchronous clear: state to IDLE, counters to 0
- enable  input  1  permits IDLE->FIRE; progress in other states is not gated
- valid_extended  input  1  level valid from the producer
- invalidate  output  1  one-cycle acknowledge to the producer
- valid_once  output  1  one-cycle pulse to the consumer
- busy  output  1  state != IDLE
- fire_count  output  COUNT_WIDTH  number of pulses emitted, saturating
- timeout_error  output  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Reset (rst high, async): state=IDLE; valid_once=0, invalidate=0, busy=0, fire_count=0, gap counter=0, timeout_error=0.
- All outputs are registered.
- States: IDLE, FIRE, RELEASE, GAP.
- IDLE:
  - If enable & valid_extended & !clear -> FIRE.
  - Else stay.
  - Latency: valid_once rises 1 cycle after valid_extended is first sampled high with enable=1.
- FIRE (exactly 1 cycle):
  - valid_once=1 and invalidate=1 in the same cycle.
  - fire_count += 1, saturating at 2^COUNT_WIDTH-1 with no wrap.
  - Next state:
    - RELEASE if REQUIRE_DEASSERT=1;
    - else GAP if GAP_CYCLES>0;
    - else IDLE.
- RELEASE:
  - Outputs 0. Wait for valid_extended==0.
  - On low -> GAP if GAP_CYCLES>0, else IDLE.
  - The same cycle that leaves RELEASE does not start a new FIRE.
- GAP:
  - Gap counter loads GAP_CYCLES on entry and decrements each cycle.
  - At 1 -> IDLE.
  - Total GAP residency is exactly GAP_CYCLES cycles.
  - valid_extended is ignored during GAP.
- Minimum spacing between rising edges of valid_once:
  - REQUIRE_DEASSERT=0: 1+GAP_CYCLES+1 cycles.
  - REQUIRE_DEASSERT=1: adds at least 1 RELEASE cycle.
- clear:
  - Has priority over every transition.
  - Next cycle: state=IDLE, valid_once=0, invalidate=0, fire_count=0, gap counter=0, timeout_error=0.
  - A clear coinciding with FIRE entry suppresses the pulse.
- enable low in IDLE: a pending level stays un-fired, with no pulse and no invalidate. It fires 1 cycle after enable rises if the level is still high.
- enable low in FIRE/RELEASE/GAP: no effect; the sequence completes.
- valid_extended dropping between IDLE sampling and FIRE: the pulse still fires. The transition is committed on the sampling edge.
- Simultaneous clear and rst: rst dominates (asynchronous).
- busy=1 in FIRE, RELEASE, GAP.

Optional Feature:
- Macro: ERVP_VALID_ONCE_GENERATOR_TIMEOUT_EN
- Defined:
  - A RELEASE-state counter counts cycles with valid_extended high.
  - On reaching TIMEOUT_CYCLES: timeout_error is set (sticky until clear/rst), and the state proceeds as if the level had dropped (GAP or IDLE).
  - The counter resets on RELEASE entry.
- Undefined:
  - No counter logic.
  - timeout_error is constant 0.
  - RELEASE waits indefinitely.

Test Plan:
- Reset release, enable=1, valid_extended rises at cycle 5 -> valid_once=1 and invalidate=1 at cycle 6 only; fire_count=1; busy 0 again once RELEASE is satisfied.
- GAP_CYCLES=3, REQUIRE_DEASSERT=0, valid_extended held high -> pulses at cycles 6, 11, 16 (period 5); fire_count=3 after cycle 16.
- REQUIRE_DEASSERT=1, level held high 10 cycles after the pulse -> exactly one pulse; the second pulse comes 1 cycle after the level re-rises following a low sample.
- enable=0 with valid_extended high for 8 cycles, then enable=1 -> no pulse during those 8 cycles; one pulse 1 cycle after enable rises. Clear asserted on the IDLE->FIRE edge -> no pulse; fire_count=0.
- COUNT_WIDTH=2, 5 pulses -> fire_count reads 1, 2, 3, 3, 3.
- Macro defined, TIMEOUT_CYCLES=4, level stuck high after FIRE -> timeout_error=1 after 4 RELEASE cycles, state returns to IDLE, flag holds until clear. Macro undefined, same stimulus -> busy stays 1, timeout_error=0.
